// File: rtl/multichannel_iir_filter.sv
`default_nettype none
// ============================================================================
// multichannel_iir_filter
// Bank of N_CH first-order IIR filters sharing one multiplier, one channel
// per cycle; outputs and saturation flags commit together at frame end.
// Revision: 1.0
// ============================================================================
module multichannel_iir_filter #(
    parameter int N_CH   = 4,
    parameter int WIDTH  = 18,
    parameter int COEF_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [COEF_W-1:0]     coef,
    input  logic [N_CH*WIDTH-1:0] v_in,
    input  logic                  clr_sat,
    output logic                  busy,
    output logic                  out_valid,
    output logic [N_CH*WIDTH-1:0] v_out,
    output logic [N_CH-1:0]       sat
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW   = WIDTH + COEF_W + 2;

    localparam logic [1:0] MODE_BYP  = 2'b00;
    localparam logic [1:0] MODE_LP   = 2'b01;
    localparam logic [1:0] MODE_HP   = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam logic signed [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CH_W-1:0]         r_ch;
    logic [1:0]              r_mode;
    logic [COEF_W-1:0]       r_coef;
    logic signed [WIDTH-1:0] r_x     [N_CH];
    logic signed [WIDTH-1:0] r_y     [N_CH];
    logic signed [WIDTH-1:0] r_stage [N_CH];
    logic signed [WIDTH-1:0] r_vout  [N_CH];
    logic [N_CH-1:0]         r_sat;
    logic [N_CH-1:0]         r_pend;

    logic                    w_accept;
    logic                    w_last;
    logic signed [WIDTH-1:0] w_x;
    logic signed [WIDTH-1:0] w_y;
    logic signed [WIDTH:0]   w_e;
    logic signed [PW-1:0]    w_e_ext;
    logic signed [PW-1:0]    w_c_ext;
    logic signed [PW-1:0]    w_p;
    logic signed [WIDTH+1:0] w_d;
    logic signed [WIDTH+1:0] w_yn;
    logic                    w_yn_clip;
    logic signed [WIDTH-1:0] w_ys;
    logic signed [WIDTH:0]   w_hp;
    logic                    w_hp_clip;
    logic signed [WIDTH-1:0] w_hps;
    logic signed [WIDTH-1:0] w_y_nxt;
    logic signed [WIDTH-1:0] w_out_nxt;
    logic                    w_set;
    logic [N_CH-1:0]         w_set_vec;
    logic                    w_unused;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_last    = (r_ch == CH_W'(N_CH - 1));
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign sat       = r_sat;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CALC;
            CALC:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared datapath for the channel selected by r_ch
    // ------------------------------------------------------------------
    assign w_x     = r_x[r_ch];
    assign w_y     = r_y[r_ch];
    assign w_e     = {w_x[WIDTH-1], w_x} - {w_y[WIDTH-1], w_y};
    assign w_e_ext = {{(PW-WIDTH-1){w_e[WIDTH]}}, w_e};
    assign w_c_ext = {{(PW-COEF_W){1'b0}}, r_coef};
    assign w_p     = w_e_ext * w_c_ext;
    // Dropping the low COEF_W bits of a two's-complement product floors it.
    assign w_d     = w_p[PW-1:COEF_W];
    assign w_unused = ^w_p[COEF_W-1:0];

    assign w_yn      = {{2{w_y[WIDTH-1]}}, w_y} + w_d;
    assign w_yn_clip = (w_yn[WIDTH+1:WIDTH-1] != 3'b000) &&
                       (w_yn[WIDTH+1:WIDTH-1] != 3'b111);
    assign w_ys      = w_yn_clip ? (w_yn[WIDTH+1] ? C_MIN : C_MAX)
                                 : w_yn[WIDTH-1:0];

    assign w_hp      = {w_x[WIDTH-1], w_x} - {w_ys[WIDTH-1], w_ys};
    assign w_hp_clip = (w_hp[WIDTH] != w_hp[WIDTH-1]);
    assign w_hps     = w_hp_clip ? (w_hp[WIDTH] ? C_MIN : C_MAX)
                                 : w_hp[WIDTH-1:0];

    always_comb begin
        w_y_nxt   = w_y;
        w_out_nxt = r_stage[r_ch];
        w_set     = 1'b0;
        case (r_mode)
            MODE_BYP: begin
                w_y_nxt   = w_x;
                w_out_nxt = w_x;
            end
            MODE_LP: begin
                w_y_nxt   = w_ys;
                w_out_nxt = w_ys;
                w_set     = w_yn_clip;
            end
            MODE_HP: begin
                w_y_nxt   = w_ys;
                w_out_nxt = w_hps;
                w_set     = w_yn_clip | w_hp_clip;
            end
            MODE_HOLD: begin
                w_y_nxt   = w_y;
                w_out_nxt = r_stage[r_ch];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_set_vec = '0;
        if ((r_state == CALC) && w_set) begin
            w_set_vec[r_ch] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch   <= '0;
            r_mode <= '0;
            r_coef <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_x[k]     <= '0;
                r_y[k]     <= '0;
                r_stage[k] <= '0;
                r_vout[k]  <= '0;
            end
        end else if (w_accept) begin
            r_ch   <= '0;
            r_mode <= mode;
            r_coef <= coef;
            for (int k = 0; k < N_CH; k++) begin
                r_x[k] <= v_in[k*WIDTH +: WIDTH];
            end
        end else if (r_state == CALC) begin
            r_y[r_ch]     <= w_y_nxt;
            r_stage[r_ch] <= w_out_nxt;
            if (w_last) begin
                // Last channel's result bypasses the staging register.
                for (int k = 0; k < N_CH; k++) begin
                    r_vout[k] <= (r_ch == CH_W'(k)) ? w_out_nxt : r_stage[k];
                end
            end else begin
                r_ch <= r_ch + 1'b1;
            end
        end
    end

    // Clamp events accumulate over the frame and reach sat at commit time,
    // where a coincident clr_sat loses to them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_sat  <= '0;
        end else begin
            if (w_accept) begin
                r_pend <= '0;
            end else if (r_state == CALC) begin
                r_pend <= r_pend | w_set_vec;
            end

            if ((r_state == CALC) && w_last) begin
                r_sat <= (r_sat & ~{N_CH{clr_sat}}) | r_pend | w_set_vec;
            end else if (clr_sat) begin
                r_sat <= '0;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_pack
        assign v_out[k*WIDTH +: WIDTH] = r_vout[k];
    end

endmodule
`default_nettype wire
